// File: rtl/cpu_run_ctrl.sv
// Run controller for the single-cycle CPU: resets the core, runs it until halt or cycle budget, signs rf data.
// Optional: define CPU_HALT_ADDR_EN to also halt when i_pc equals HALT_ADDR.
module cpu_run_ctrl #(
    parameter int              DATA_W      = 32,
    parameter int              PC_W        = 32,
    parameter int              SIG_W       = 32,
    parameter int              CNT_W       = 16,
    parameter int              RST_CYCLES  = 2,
    parameter int              MAX_CYCLES  = 24,
    parameter int              HALT_REPEAT = 3,
    parameter logic [PC_W-1:0] HALT_ADDR   = '0
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic [PC_W-1:0]   i_pc,
    input  logic [DATA_W-1:0] i_rf_data,
    output logic              o_cpu_rst_n,
    output logic              o_running,
    output logic              o_done,
    output logic              o_halted,
    output logic              o_timeout,
    output logic [CNT_W-1:0]  o_cycle_cnt,
    output logic [SIG_W-1:0]  o_signature
);

    localparam int RST_CNT_W = $clog2(RST_CYCLES) + 1;
    localparam int STALL_W   = $clog2(HALT_REPEAT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RESET,
        S_RUN,
        S_DONE
    } state_e;

    state_e               state_q;
    logic [RST_CNT_W-1:0] rst_cnt_q;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [SIG_W-1:0]     sig_q, sig_d;
    logic [PC_W-1:0]      prev_pc_q;
    logic [STALL_W-1:0]   stall_q, stall_d;
    logic                 cpu_rst_n_q, running_q, done_q, halted_q, timeout_q;
    logic                 addr_hit, halt_hit, tmo_hit;

    // The first RUN cycle is recognised by the freshly cleared counter; it has no previous PC to compare.
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        sig_d = {sig_q[SIG_W-2:0], sig_q[SIG_W-1]} ^ SIG_W'(i_rf_data);
        stall_d = '0;
        if (cnt_q != '0 && i_pc == prev_pc_q) begin
            stall_d = stall_q + STALL_W'(1);
        end
`ifdef CPU_HALT_ADDR_EN
        addr_hit = (i_pc == HALT_ADDR);
`else
        addr_hit = (i_pc == HALT_ADDR) & 1'b0;
`endif
        halt_hit = (stall_d == STALL_W'(HALT_REPEAT)) || addr_hit;
        tmo_hit  = (cnt_d == CNT_W'(MAX_CYCLES));
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= S_IDLE;
            rst_cnt_q   <= '0;
            cnt_q       <= '0;
            sig_q       <= '0;
            prev_pc_q   <= '0;
            stall_q     <= '0;
            cpu_rst_n_q <= 1'b0;
            running_q   <= 1'b0;
            done_q      <= 1'b0;
            halted_q    <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (i_start) begin
                        state_q   <= S_RESET;
                        rst_cnt_q <= '0;
                        cnt_q     <= '0;
                        sig_q     <= '0;
                        prev_pc_q <= '0;
                        stall_q   <= '0;
                        done_q    <= 1'b0;
                        halted_q  <= 1'b0;
                        timeout_q <= 1'b0;
                    end
                end
                S_RESET: begin
                    if (rst_cnt_q == RST_CNT_W'(RST_CYCLES - 1)) begin
                        state_q     <= S_RUN;
                        cpu_rst_n_q <= 1'b1;
                        running_q   <= 1'b1;
                    end else begin
                        rst_cnt_q <= rst_cnt_q + RST_CNT_W'(1);
                    end
                end
                S_RUN: begin
                    cnt_q     <= cnt_d;
                    sig_q     <= sig_d;
                    prev_pc_q <= i_pc;
                    stall_q   <= stall_d;
                    // Halt takes priority when it coincides with the budget running out.
                    if (halt_hit || tmo_hit) begin
                        state_q     <= S_DONE;
                        cpu_rst_n_q <= 1'b0;
                        running_q   <= 1'b0;
                        done_q      <= 1'b1;
                        halted_q    <= halt_hit;
                        timeout_q   <= !halt_hit;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign o_cpu_rst_n = cpu_rst_n_q;
    assign o_running   = running_q;
    assign o_done      = done_q;
    assign o_halted    = halted_q;
    assign o_timeout   = timeout_q;
    assign o_cycle_cnt = cnt_q;
    assign o_signature = sig_q;

endmodule
